hbram_port_arbiter: RTL and testbench

- Shares the single HyperRAM burst controller between up to four requesters: CSI frame write, HDMI scan-out read, DSI scan-out read, and the UART/debug port.
- Sits between the per-stream FIFOs and the hbram controller, in the controller's clock domain.
- Picks one requester at a time using two-level priority. Round-robin applies within each level.
- Issues one burst command, then holds the grant until the controller reports the burst finished.

---
 rtl/hbram_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_hbram_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbram_port_arbiter.sv
`default_nettype none
// ============================================================================
// hbram_port_arbiter - two-class round-robin arbiter for the shared HyperRAM
// burst controller; define HBRAM_ARB_STARVE_GUARD_EN to add low-class promotion.
// Rev 1.0
// ============================================================================
module hbram_port_arbiter #(
  parameter int                 NUM_REQ      = 4,
  parameter int                 ADDR_W       = 22,
  parameter int                 LEN_W        = 8,
  parameter logic [NUM_REQ-1:0] HI_PRIO_MASK = 4'b0110,
  parameter int                 DONE_TIMEOUT = 1023,
  parameter int                 STARVE_LIMIT = 8
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic                      cmd_we_o,
  output logic [ADDR_W-1:0]         cmd_addr_o,
  output logic [LEN_W-1:0]          cmd_len_o,
  input  logic                      burst_done_i,
  output logic                      timeout_err_o,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DONE_TIMEOUT < 1 || STARVE_LIMIT < 1) begin : g_param_chk
    $error("hbram_port_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, r_done;
  logic [PTR_W-1:0]     r_hi_ptr, r_lo_ptr;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic                 r_tmo_err, r_cmd_we;
  logic [ADDR_W-1:0]    r_cmd_addr;
  logic [LEN_W-1:0]     r_cmd_len;

  logic                 w_arb_fire, w_ack_fire, w_done_fire, w_tmo_fire;
  logic [NUM_REQ-1:0]   w_promote, w_hi_mask, w_cand, w_win_oh;
  logic                 w_use_hi, w_found;
  logic [PTR_W-1:0]     w_ptr, w_win_idx, w_ptr_nxt;
  logic [PTR_W:0]       w_sum;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [LEN_W-1:0]     w_sel_len;

`ifdef HBRAM_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  // A low-class port that keeps losing while valid competes as high class.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
    if (HI_PRIO_MASK[gi]) begin : g_hi_port
      assign w_promote[gi] = 1'b0;
    end else begin : g_lo_port
      logic [SC_W-1:0] r_cnt;
      always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i)
          r_cnt <= '0;
        else if (!req_valid_i[gi] || (w_arb_fire && w_win_oh[gi]))
          r_cnt <= '0;
        else if (w_arb_fire && (r_cnt != SC_W'(STARVE_LIMIT)))
          r_cnt <= r_cnt + 1'b1;
      end
      assign w_promote[gi] = (r_cnt == SC_W'(STARVE_LIMIT));
    end
  end
`else
  assign w_promote = '0;
`endif

  // Winner search: first valid port at or after the active class pointer.
  always_comb begin
    w_hi_mask = HI_PRIO_MASK | w_promote;
    w_use_hi  = |(req_valid_i & w_hi_mask);
    w_cand    = req_valid_i & (w_use_hi ? w_hi_mask : ~w_hi_mask);
    w_ptr     = w_use_hi ? r_hi_ptr : r_lo_ptr;
    w_sum     = '0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ))
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      if (w_cand[w_sum[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_sum[PTR_W-1:0];
      end
    end
    w_win_oh = '0;
    if (w_found)
      w_win_oh[w_win_idx] = 1'b1;
    w_ptr_nxt = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (w_win_oh[p]) begin
        w_sel_we   = req_we_i[p];
        w_sel_addr = req_addr_i[p*ADDR_W +: ADDR_W];
        w_sel_len  = req_len_i[p*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb_fire  = 1'b0;
    w_ack_fire  = 1'b0;
    w_done_fire = 1'b0;
    w_tmo_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid_i) begin
          w_arb_fire  = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready_i) begin
          w_ack_fire  = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A real end-of-burst in the final cycle wins over the timeout.
        if (burst_done_i) begin
          w_done_fire = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_tmo_cnt == TMO_W'(DONE_TIMEOUT - 1)) begin
          w_done_fire = 1'b1;
          w_tmo_fire  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_grant    <= '0;
      r_done     <= '0;
      r_hi_ptr   <= '0;
      r_lo_ptr   <= '0;
      r_tmo_cnt  <= '0;
      r_tmo_err  <= 1'b0;
      r_cmd_we   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_len  <= '0;
    end else begin
      r_done <= w_done_fire ? r_grant : '0;
      if (w_arb_fire) begin
        r_grant    <= w_win_oh;
        r_cmd_we   <= w_sel_we;
        r_cmd_addr <= w_sel_addr;
        r_cmd_len  <= w_sel_len;
        if (w_use_hi)
          r_hi_ptr <= w_ptr_nxt;
        else
          r_lo_ptr <= w_ptr_nxt;
      end else if (w_done_fire) begin
        r_grant <= '0;
      end
      r_tmo_cnt <= ((r_state == ST_WAIT) && !w_done_fire) ? r_tmo_cnt + 1'b1 : '0;
      if (w_tmo_fire)
        r_tmo_err <= 1'b1;
    end
  end

  assign cmd_valid_o   = (r_state == ST_ISSUE);
  assign req_ack_o     = r_grant & {NUM_REQ{w_ack_fire}};
  assign req_done_o    = r_done;
  assign grant_o       = r_grant;
  assign cmd_we_o      = r_cmd_we;
  assign cmd_addr_o    = r_cmd_addr;
  assign cmd_len_o     = r_cmd_len;
  assign timeout_err_o = r_tmo_err;
  assign busy_o        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hbram_port_arbiter.sv
`default_nettype none
// tb_hbram_port_arbiter - directed bench for the 4-port arbiter, mask 4'b0110.
module tb_hbram_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 22;
  localparam int LEN_W   = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ack, req_done, grant;
  logic                      cmd_valid, cmd_ready, cmd_we, burst_done, tmo_err, busy;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [LEN_W-1:0]          cmd_len;

  int n_vec = 0;
  int n_err = 0;
  int n_p0, n_done;

  hbram_port_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ADDR_W       (ADDR_W),
    .LEN_W        (LEN_W),
    .HI_PRIO_MASK (4'b0110),
    .DONE_TIMEOUT (1023),
    .STARVE_LIMIT (8)
  ) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst),
    .req_valid_i   (req_valid),
    .req_we_i      (req_we),
    .req_addr_i    (req_addr),
    .req_len_i     (req_len),
    .req_ack_o     (req_ack),
    .req_done_o    (req_done),
    .grant_o       (grant),
    .cmd_valid_o   (cmd_valid),
    .cmd_ready_i   (cmd_ready),
    .cmd_we_o      (cmd_we),
    .cmd_addr_o    (cmd_addr),
    .cmd_len_o     (cmd_len),
    .burst_done_i  (burst_done),
    .timeout_err_o (tmo_err),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`define CHK(t, o, e) chk(t, 32'(o), 32'(e))

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic w, input logic [21:0] a, input logic [7:0] l);
    req_we[p] = w;
    req_addr[p*ADDR_W +: ADDR_W] = a;
    req_len[p*LEN_W +: LEN_W] = l;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
    cmd_ready = 1'b0; burst_done = 1'b0;
    repeat (3) @(posedge clk);
    smp();
    `CHK("rst_grant", grant, 4'b0000);
    `CHK("rst_cmdv", cmd_valid, 1'b0);
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_err", tmo_err, 1'b0);
    `CHK("rst_done", req_done, 4'b0000);
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $error("FAIL rst_inline: observed grant %0h busy %0b expected 0 0", grant, busy);
    end
    nxt(); rst = 1'b0;

    // Priority: ports 0 and 2 together, high-class port 2 first.
    set_port(0, 1'b1, 22'h000100, 8'd3);
    set_port(2, 1'b0, 22'h000200, 8'd7);
    req_valid = 4'b0101;
    smp();
    `CHK("prio_latency_cmdv", cmd_valid, 1'b0);
    nxt();
    smp();
    `CHK("prio_grant_p2", grant, 4'b0100);
    `CHK("prio_cmdv", cmd_valid, 1'b1);
    `CHK("prio_addr", cmd_addr, 22'h000200);
    `CHK("prio_len", cmd_len, 8'd7);
    `CHK("prio_we", cmd_we, 1'b0);
    `CHK("prio_noack", req_ack, 4'b0000);
    n_vec++;
    if (grant !== 4'b0100) begin
      n_err++;
      $error("FAIL prio_inline: observed %0h expected 4", grant);
    end
    nxt(); cmd_ready = 1'b1;
    smp();
    `CHK("prio_ack_p2", req_ack, 4'b0100);
    nxt(); cmd_ready = 1'b0; req_valid = 4'b0001; burst_done = 1'b1;
    smp();
    `CHK("prio_wait_cmdv", cmd_valid, 1'b0);
    `CHK("prio_wait_grant", grant, 4'b0100);
    nxt(); burst_done = 1'b0;
    smp();
    `CHK("prio_done_p2", req_done, 4'b0100);
    `CHK("prio_idle_grant", grant, 4'b0000);
    nxt(); cmd_ready = 1'b1;
    smp();
    `CHK("prio_grant_p0", grant, 4'b0001);
    `CHK("prio_addr_p0", cmd_addr, 22'h000100);
    `CHK("prio_len_p0", cmd_len, 8'd3);
    `CHK("prio_we_p0", cmd_we, 1'b1);
    `CHK("prio_ack_p0", req_ack, 4'b0001);
    nxt(); cmd_ready = 1'b0; req_valid = 4'b0000; burst_done = 1'b1;
    nxt(); burst_done = 1'b0;
    smp();
    `CHK("prio_done_p0", req_done, 4'b0001);

    // Reset asserted mid-burst with port 2 owning the controller.
    set_port(2, 1'b0, 22'h0ABCDE, 8'd5);
    req_valid = 4'b0100; cmd_ready = 1'b1;
    nxt();
    smp();
    `CHK("rstmid_grant", grant, 4'b0100);
    `CHK("rstmid_ack", req_ack, 4'b0100);
    nxt(); req_valid = 4'b0000; cmd_ready = 1'b0;
    smp();
    `CHK("rstmid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    `CHK("rstasync_grant", grant, 4'b0000);
    `CHK("rstasync_busy", busy, 1'b0);
    `CHK("rstasync_cmdv", cmd_valid, 1'b0);
    `CHK("rstasync_addr", cmd_addr, 22'h0);
    `CHK("rstasync_len", cmd_len, 8'h0);
    `CHK("rstasync_we", cmd_we, 1'b0);
    `CHK("rstasync_done", req_done, 4'b0000);
    `CHK("rstasync_err", tmo_err, 1'b0);
    n_vec++;
    if (grant !== 4'b0000 || cmd_valid !== 1'b0) begin
      n_err++;
      $error("FAIL rstasync_inline: observed grant %0h cmdv %0b expected 0 0", grant, cmd_valid);
    end
    nxt(); nxt(); rst = 1'b0;
    set_port(0, 1'b1, 22'h000055, 8'd2);
    req_valid = 4'b0001;
    smp();
    `CHK("postrst_early_cmdv", cmd_valid, 1'b0);
    `CHK("postrst_early_grant", grant, 4'b0000);
    nxt(); cmd_ready = 1'b1;
    smp();
    `CHK("postrst_grant", grant, 4'b0001);
    `CHK("postrst_cmdv", cmd_valid, 1'b1);
    `CHK("postrst_addr", cmd_addr, 22'h000055);
    `CHK("postrst_ack", req_ack, 4'b0001);
    nxt(); cmd_ready = 1'b0; req_valid = 4'b0000; burst_done = 1'b1;
    nxt(); burst_done = 1'b0;
    smp();
    `CHK("postrst_done", req_done, 4'b0001);

    // Round-robin within the high class: 1,2,1,2.
    req_valid = 4'b0110; cmd_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      logic [3:0] exp_g;
      exp_g = (b % 2 == 0) ? 4'b0010 : 4'b0100;
      nxt();
      smp();
      `CHK("rr_grant", grant, exp_g);
      `CHK("rr_ack", req_ack, exp_g);
      n_vec++;
      if (grant !== exp_g) begin
        n_err++;
        $error("FAIL rr_grant_inline: observed %0h expected %0h", grant, exp_g);
      end
      nxt(); nxt(); nxt();
      nxt(); burst_done = 1'b1;
      smp();
      `CHK("rr_done_not_yet", req_done, 4'b0000);
      nxt(); burst_done = 1'b0;
      if (b == 3) req_valid = 4'b0000;
      smp();
      `CHK("rr_done", req_done, exp_g);
      `CHK("rr_idle_grant", grant, 4'b0000);
      n_vec++;
      if (req_done !== exp_g) begin
        n_err++;
        $error("FAIL rr_done_inline: observed %0h expected %0h", req_done, exp_g);
      end
    end

    // Command latch: port 3 at the field maxima, 10 cycles of back-pressure.
    cmd_ready = 1'b0;
    set_port(3, 1'b1, 22'h3FFFFF, 8'hFF);
    req_valid = 4'b1000;
    nxt();
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        req_valid = 4'b0010;
        set_port(3, 1'b0, 22'h000000, 8'h00);
      end
      burst_done = (i == 3);
      smp();
      `CHK("latch_cmdv", cmd_valid, 1'b1);
      `CHK("latch_addr", cmd_addr, 22'h3FFFFF);
      `CHK("latch_len", cmd_len, 8'hFF);
      `CHK("latch_we", cmd_we, 1'b1);
      `CHK("latch_noack", req_ack, 4'b0000);
      `CHK("latch_grant", grant, 4'b1000);
      n_vec++;
      if (cmd_addr !== 22'h3FFFFF || cmd_len !== 8'hFF) begin
        n_err++;
        $error("FAIL latch_inline: observed %0h/%0h expected 3fffff/ff", cmd_addr, cmd_len);
      end
      nxt();
    end
    req_valid = 4'b0000; cmd_ready = 1'b1;
    smp();
    `CHK("latch_ack", req_ack, 4'b1000);
    `CHK("latch_addr_hs", cmd_addr, 22'h3FFFFF);
    nxt(); cmd_ready = 1'b0; burst_done = 1'b1;
    smp();
    `CHK("latch_cmdv_drop", cmd_valid, 1'b0);
    `CHK("latch_ack_drop", req_ack, 4'b0000);
    nxt(); burst_done = 1'b0;
    smp();
    `CHK("latch_done", req_done, 4'b1000);
    `CHK("latch_err", tmo_err, 1'b0);

    // Timeout: port 0 granted, burst_done never arrives.
    set_port(0, 1'b0, 22'h012345, 8'h10);
    req_valid = 4'b0001; cmd_ready = 1'b1;
    nxt();
    smp();
    `CHK("tmo_grant", grant, 4'b0001);
    `CHK("tmo_ack", req_ack, 4'b0001);
    nxt(); req_valid = 4'b0000; cmd_ready = 1'b0;
    repeat (1022) nxt();
    smp();
    `CHK("tmo_busy_before", busy, 1'b1);
    `CHK("tmo_err_before", tmo_err, 1'b0);
    `CHK("tmo_done_before", req_done, 4'b0000);
    nxt();
    smp();
    `CHK("tmo_err", tmo_err, 1'b1);
    `CHK("tmo_done", req_done, 4'b0001);
    `CHK("tmo_busy", busy, 1'b0);
    `CHK("tmo_grant_clr", grant, 4'b0000);
    n_vec++;
    if (tmo_err !== 1'b1 || req_done !== 4'b0001) begin
      n_err++;
      $error("FAIL tmo_inline: observed err %0b done %0h expected 1 1", tmo_err, req_done);
    end
    nxt();
    smp();
    `CHK("tmo_err_sticky", tmo_err, 1'b1);
    `CHK("tmo_done_pulse", req_done, 4'b0000);

    // Continuous high-class load against low-class port 0.
    req_valid = 4'b0111; cmd_ready = 1'b1; burst_done = 1'b1;
    n_p0 = 0; n_done = 0;
    for (int i = 0; i < 300; i++) begin
      nxt();
      smp();
      if (grant[0]) n_p0++;
      if (|req_done) n_done++;
    end
    req_valid = 4'b0000; cmd_ready = 1'b0; burst_done = 1'b0;
`ifdef HBRAM_ARB_STARVE_GUARD_EN
    `CHK("starve_p0_promoted", (n_p0 > 0), 1'b1);
`else
    `CHK("starve_p0_grants", n_p0, 0);
`endif
    `CHK("starve_bursts", n_done, 100);
    `CHK("starve_err_sticky", tmo_err, 1'b1);
    n_vec++;
    if (n_done != 100) begin
      n_err++;
      $error("FAIL starve_bursts_inline: observed %0d expected 100", n_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
